// File: rtl/switch_pkg.sv
// Shared definitions for the egress transmit path: CRC-32 constants,
// GMII framing bytes and the framer state encoding.
package switch_pkg;

  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;

  localparam logic [7:0]  GMII_PREAMBLE   = 8'h55;
  localparam logic [7:0]  GMII_SFD        = 8'hD5;

  // Frame length field width inside the pointer word.
  localparam int          LEN_W           = 12;

  // State encodings. FETCH covers the cycle where the pointer pop is on
  // the wire but the FIFO output is not valid yet.
  localparam logic [3:0]  ST_IDLE_ENC     = 4'd0;
  localparam logic [3:0]  ST_FETCH_ENC    = 4'd1;
  localparam logic [3:0]  ST_PTR_ENC      = 4'd2;
  localparam logic [3:0]  ST_PRE_ENC      = 4'd3;
  localparam logic [3:0]  ST_SFD_ENC      = 4'd4;
  localparam logic [3:0]  ST_DATA_ENC     = 4'd5;
  localparam logic [3:0]  ST_PAD_ENC      = 4'd6;
  localparam logic [3:0]  ST_FCS_ENC      = 4'd7;
  localparam logic [3:0]  ST_IFG_ENC      = 4'd8;

  typedef enum logic [3:0] {
    ST_IDLE  = ST_IDLE_ENC,
    ST_FETCH = ST_FETCH_ENC,
    ST_PTR   = ST_PTR_ENC,
    ST_PRE   = ST_PRE_ENC,
    ST_SFD   = ST_SFD_ENC,
    ST_DATA  = ST_DATA_ENC,
    ST_PAD   = ST_PAD_ENC,
    ST_FCS   = ST_FCS_ENC,
    ST_IFG   = ST_IFG_ENC
  } tx_state_e;

endpackage

// File: rtl/crc32_d8.sv
// Combinational Ethernet CRC-32 update for one byte (LSB-first, reflected
// polynomial). The caller owns the CRC register.
module crc32_d8
  import switch_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  // Shift the byte in one bit at a time, least significant bit first.
  always_comb begin
    crc_out = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (crc_out[0] ^ data[i]) begin
        crc_out = (crc_out >> 1) ^ CRC32_POLY_REFL;
      end else begin
        crc_out = crc_out >> 1;
      end
    end
  end

endmodule

// File: rtl/switch_tx_framer.sv
// Per-port egress MAC transmit stage. Pops a frame pointer, streams the
// frame bytes from the data FIFO onto GMII wrapped in preamble/SFD, pads
// short frames, appends the FCS and then holds the inter-frame gap.
//
// Every output is a flop loaded from the *_next values, so the state held
// in a given cycle decides what appears on the pins one cycle later. The
// data FIFO pop therefore runs two cycles ahead of the byte on GMII: the
// first pop goes out with the last preamble byte and the pop for byte i+2
// goes out while byte i is on the wire.
//
// PREAMBLE_LEN must be at least 1.
module switch_tx_framer
  import switch_pkg::*;
#(
  parameter int MIN_LEN      = 60,
  parameter int IFG_LEN      = 12,
  parameter int PREAMBLE_LEN = 7
) (
  input  logic        clk,
  input  logic        rstn,
  output logic        ptr_fifo_rd,
  input  logic [15:0] ptr_fifo_dout,
  input  logic        ptr_fifo_empty,
  output logic        data_fifo_rd,
  input  logic [7:0]  data_fifo_dout,
  output logic [7:0]  gmii_txd,
  output logic        gmii_tx_en,
  output logic        gmii_tx_er,
  output logic        tx_frame_done
);

  localparam logic [LEN_W-1:0] MIN_LEN_C  = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0] MIN_LAST_C = LEN_W'(MIN_LEN - 1);
  localparam logic [LEN_W-1:0] PRE_LAST_C = LEN_W'(PREAMBLE_LEN - 1);
  localparam logic [LEN_W-1:0] IFG_LAST_C = LEN_W'(IFG_LEN - 1);

  tx_state_e        state_reg, state_next;
  logic [LEN_W-1:0] len_reg, len_next;
  logic [LEN_W-1:0] cnt_reg, cnt_next;
  logic [31:0]      crc_reg, crc_next;

  logic             ptr_rd_reg, ptr_rd_next;
  logic             data_rd_reg, data_rd_next;
  logic [7:0]       txd_reg, txd_next;
  logic             tx_en_reg, tx_en_next;
  logic             tx_er_reg;
  logic             done_reg, done_next;

  logic [7:0]       crc_byte;
  logic [31:0]      crc_upd;
  logic [31:0]      fcs_word;
  logic [7:0]       fcs_byte [0:3];

  // The upper pointer bits carry nothing this stage needs.
  logic             ptr_rsvd_unused;
  assign ptr_rsvd_unused = ^ptr_fifo_dout[15:12];

  // Pad bytes are zero; everything else folded into the CRC comes from the FIFO.
  assign crc_byte = (state_reg == ST_PAD) ? 8'h00 : data_fifo_dout;

  crc32_d8 u_crc (
    .crc_in  (crc_reg),
    .data    (crc_byte),
    .crc_out (crc_upd)
  );

  // The FCS is the inverted CRC, sent least significant byte first.
  assign fcs_word = ~crc_reg;
  for (genvar gi = 0; gi < 4; gi++) begin : g_fcs
    assign fcs_byte[gi] = fcs_word[8*gi +: 8];
  end

  // Next-state and next-output decode; defaults leave the line idle.
  always_comb begin
    state_next   = state_reg;
    len_next     = len_reg;
    cnt_next     = cnt_reg;
    crc_next     = crc_reg;
    ptr_rd_next  = 1'b0;
    data_rd_next = 1'b0;
    txd_next     = 8'h00;
    tx_en_next   = 1'b0;
    done_next    = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (!ptr_fifo_empty) begin
          ptr_rd_next = 1'b1;
          state_next  = ST_FETCH;
        end
      end

      ST_FETCH: begin
        state_next = ST_PTR;
      end

      ST_PTR: begin
        len_next = ptr_fifo_dout[LEN_W-1:0];
        if (ptr_fifo_dout[LEN_W-1:0] == '0) begin
          // Empty frame: drop the pointer without touching the data FIFO.
          state_next = ST_IDLE;
        end else begin
          tx_en_next = 1'b1;
          txd_next   = GMII_PREAMBLE;
          cnt_next   = LEN_W'(1);
          if (PREAMBLE_LEN <= 1) begin
            data_rd_next = 1'b1;
            state_next   = ST_SFD;
          end else begin
            state_next   = ST_PRE;
          end
        end
      end

      ST_PRE: begin
        tx_en_next = 1'b1;
        txd_next   = GMII_PREAMBLE;
        cnt_next   = cnt_reg + LEN_W'(1);
        if (cnt_reg == PRE_LAST_C) begin
          // Fetch byte 0 so it is on the FIFO output right after the SFD.
          data_rd_next = 1'b1;
          state_next   = ST_SFD;
        end
      end

      ST_SFD: begin
        tx_en_next   = 1'b1;
        txd_next     = GMII_SFD;
        crc_next     = CRC32_INIT;
        cnt_next     = '0;
        data_rd_next = (len_reg > LEN_W'(1));
        state_next   = ST_DATA;
      end

      ST_DATA: begin
        tx_en_next   = 1'b1;
        txd_next     = data_fifo_dout;
        crc_next     = crc_upd;
        cnt_next     = cnt_reg + LEN_W'(1);
        // Keep the pop two bytes ahead; stops once all len bytes are requested.
        data_rd_next = (({1'b0, cnt_reg} + 13'd2) < {1'b0, len_reg});
        if (cnt_reg == len_reg - LEN_W'(1)) begin
          if (len_reg < MIN_LEN_C) begin
            // cnt carries on as the total pre-FCS byte index.
            state_next = ST_PAD;
          end else begin
            cnt_next   = '0;
            state_next = ST_FCS;
          end
        end
      end

      ST_PAD: begin
        tx_en_next = 1'b1;
        txd_next   = 8'h00;
        crc_next   = crc_upd;
        cnt_next   = cnt_reg + LEN_W'(1);
        if (cnt_reg == MIN_LAST_C) begin
          cnt_next   = '0;
          state_next = ST_FCS;
        end
      end

      ST_FCS: begin
        tx_en_next = 1'b1;
        txd_next   = fcs_byte[cnt_reg[1:0]];
        cnt_next   = cnt_reg + LEN_W'(1);
        if (cnt_reg[1:0] == 2'd3) begin
          done_next = 1'b1;
          cnt_next  = '0;
          if (IFG_LEN == 0) begin
            state_next = ST_IDLE;
          end else begin
            state_next = ST_IFG;
          end
        end
      end

      ST_IFG: begin
        cnt_next = cnt_reg + LEN_W'(1);
        if (cnt_reg == IFG_LAST_C) begin
          cnt_next   = '0;
          state_next = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State, counters, CRC and registered outputs; reset abandons any frame.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg   <= ST_IDLE;
      len_reg     <= '0;
      cnt_reg     <= '0;
      crc_reg     <= '0;
      ptr_rd_reg  <= 1'b0;
      data_rd_reg <= 1'b0;
      txd_reg     <= 8'h00;
      tx_en_reg   <= 1'b0;
      tx_er_reg   <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      len_reg     <= len_next;
      cnt_reg     <= cnt_next;
      crc_reg     <= crc_next;
      ptr_rd_reg  <= ptr_rd_next;
      data_rd_reg <= data_rd_next;
      txd_reg     <= txd_next;
      tx_en_reg   <= tx_en_next;
      tx_er_reg   <= 1'b0;
      done_reg    <= done_next;
    end
  end

  assign ptr_fifo_rd   = ptr_rd_reg;
  assign data_fifo_rd  = data_rd_reg;
  assign gmii_txd      = txd_reg;
  assign gmii_tx_en    = tx_en_reg;
  assign gmii_tx_er    = tx_er_reg;
  assign tx_frame_done = done_reg;

endmodule

// File: tb/tb_switch_tx_framer.sv
// Directed bench for switch_tx_framer: FIFO models feed the DUT, a GMII
// monitor captures each frame and compares it against a scoreboard of
// expected byte streams built when the stimulus is queued.
module tb_switch_tx_framer;

  logic        clk;
  logic        rstn;
  logic        ptr_fifo_rd;
  logic [15:0] ptr_fifo_dout = 16'h0;
  logic        ptr_fifo_empty = 1'b1;
  logic        data_fifo_rd;
  logic [7:0]  data_fifo_dout = 8'h00;
  logic [7:0]  gmii_txd;
  logic        gmii_tx_en;
  logic        gmii_tx_er;
  logic        tx_frame_done;

  // Second instance without padding, for the known-answer CRC frame.
  logic        n_ptr_rd;
  logic [15:0] n_ptr_dout = 16'h0;
  logic        n_ptr_empty = 1'b1;
  logic        n_data_rd;
  logic [7:0]  n_data_dout = 8'h00;
  logic [7:0]  n_txd;
  logic        n_tx_en;
  logic        n_tx_er;
  logic        n_done;

  int checks = 0;
  int errors = 0;

  logic [15:0] ptr_q [$];
  logic [7:0]  data_q [$];
  logic [15:0] n_ptr_q [$];
  logic [7:0]  n_data_q [$];
  int          ptr_pops = 0;
  int          data_pops = 0;

  // Scoreboard: expected frame lengths and the flat expected byte stream.
  int          exp_lens [$];
  logic [7:0]  exp_bytes [$];
  int          gap_q [$];

  logic [7:0]  pay [0:127];
  logic [7:0]  cap [0:255];
  int          cap_len = 0;
  int          frames_seen = 0;

  switch_tx_framer dut (
    .clk            (clk),
    .rstn           (rstn),
    .ptr_fifo_rd    (ptr_fifo_rd),
    .ptr_fifo_dout  (ptr_fifo_dout),
    .ptr_fifo_empty (ptr_fifo_empty),
    .data_fifo_rd   (data_fifo_rd),
    .data_fifo_dout (data_fifo_dout),
    .gmii_txd       (gmii_txd),
    .gmii_tx_en     (gmii_tx_en),
    .gmii_tx_er     (gmii_tx_er),
    .tx_frame_done  (tx_frame_done)
  );

  switch_tx_framer #(.MIN_LEN(0)) dut_nopad (
    .clk            (clk),
    .rstn           (rstn),
    .ptr_fifo_rd    (n_ptr_rd),
    .ptr_fifo_dout  (n_ptr_dout),
    .ptr_fifo_empty (n_ptr_empty),
    .data_fifo_rd   (n_data_rd),
    .data_fifo_dout (n_data_dout),
    .gmii_txd       (n_txd),
    .gmii_tx_en     (n_tx_en),
    .gmii_tx_er     (n_tx_er),
    .tx_frame_done  (n_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO models: dout updates on the edge that sees rd, i.e. valid next cycle.
  always @(posedge clk) begin
    if (ptr_fifo_rd) ptr_pops <= ptr_pops + 1;
    if (ptr_fifo_rd && ptr_q.size() > 0) ptr_fifo_dout <= ptr_q.pop_front();
    ptr_fifo_empty <= (ptr_q.size() == 0);
    if (data_fifo_rd) data_pops <= data_pops + 1;
    if (data_fifo_rd && data_q.size() > 0) data_fifo_dout <= data_q.pop_front();
  end

  always @(posedge clk) begin
    if (n_ptr_rd && n_ptr_q.size() > 0) n_ptr_dout <= n_ptr_q.pop_front();
    n_ptr_empty <= (n_ptr_q.size() == 0);
    if (n_data_rd && n_data_q.size() > 0) n_data_dout <= n_data_q.pop_front();
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] crc_ref(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  // Queue payload bytes and pointer; record the expected GMII stream.
  task automatic send_frame(input logic [15:0] ptr_word);
    int len;
    int tot;
    logic [31:0] crc;
    logic [7:0]  b;
    len = int'(ptr_word[11:0]);
    for (int i = 0; i < len; i++) data_q.push_back(pay[i]);
    if (len > 0) begin
      tot = (len < 60) ? 60 : len;
      exp_lens.push_back(8 + tot + 4);
      for (int i = 0; i < 7; i++) exp_bytes.push_back(8'h55);
      exp_bytes.push_back(8'hD5);
      crc = 32'hFFFFFFFF;
      for (int i = 0; i < tot; i++) begin
        b = (i < len) ? pay[i] : 8'h00;
        exp_bytes.push_back(b);
        crc = crc_ref(crc, b);
      end
      crc = ~crc;
      for (int k = 0; k < 4; k++) exp_bytes.push_back(crc[8*k +: 8]);
    end
    ptr_q.push_back(ptr_word);
  endtask

  task automatic compare_frame(input int done_cnt_f, input int done_idx, input logic er_f);
    int elen;
    int mism;
    logic [7:0] e;
    if (exp_lens.size() == 0) begin
      check("spurious_frame_len", 32'(cap_len), 32'd0);
      return;
    end
    elen = exp_lens.pop_front();
    check("frame_tx_en_cycles", 32'(cap_len), 32'(elen));
    mism = 0;
    for (int i = 0; i < elen; i++) begin
      e = exp_bytes.pop_front();
      if (i >= cap_len || cap[i] !== e) mism++;
    end
    check("frame_byte_mismatches", 32'(mism), 32'd0);
    check("done_pulses_in_frame", 32'(done_cnt_f), 32'd1);
    check("done_on_last_byte", 32'(done_idx), 32'(elen - 1));
    check("tx_er_in_frame", 32'(er_f), 32'd0);
  endtask

  // GMII monitor, sampling on the falling edge.
  initial begin
    int   cyc = 0;
    int   last_ptr_cyc = -100;
    int   gap = 1000;
    int   done_cnt_f = 0;
    int   done_idx = -1;
    logic er_f = 1'b0;
    logic in_frame = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (ptr_fifo_rd) last_ptr_cyc = cyc;
      if (tx_frame_done && !gmii_tx_en) check("done_outside_frame", 32'(tx_frame_done), 32'd0);
      if (!rstn) begin
        in_frame = 1'b0;
        cap_len  = 0;
      end else if (gmii_tx_en) begin
        if (!in_frame) begin
          in_frame = 1'b1;
          gap_q.push_back(gap);
          check("ptr_rd_to_preamble", 32'(cyc - last_ptr_cyc), 32'd2);
          done_cnt_f = 0;
          done_idx   = -1;
          er_f       = 1'b0;
        end
        if (cap_len < 256) cap[cap_len] = gmii_txd;
        if (tx_frame_done) begin
          done_cnt_f++;
          done_idx = cap_len;
        end
        if (gmii_tx_er) er_f = 1'b1;
        cap_len++;
      end else if (in_frame) begin
        compare_frame(done_cnt_f, done_idx, er_f);
        in_frame = 1'b0;
        cap_len  = 0;
        gap      = 1;
        frames_seen++;
      end else begin
        gap++;
      end
    end
  end

  task automatic wait_frames(input int target, input int budget);
    int n;
    n = 0;
    while (frames_seen < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("frames_completed", 32'(frames_seen >= target), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int p0;
    int d0;
    int n;
    int n0;
    int en_cnt;
    logic got;
    logic [7:0] cap0 [0:63];
    string kat;

    // Reset state.
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_gmii_txd", 32'(gmii_txd), 32'h0);
    check("rst_gmii_tx_en", 32'(gmii_tx_en), 32'h0);
    check("rst_gmii_tx_er", 32'(gmii_tx_er), 32'h0);
    check("rst_tx_frame_done", 32'(tx_frame_done), 32'h0);
    check("rst_ptr_fifo_rd", 32'(ptr_fifo_rd), 32'h0);
    check("rst_data_fifo_rd", 32'(data_fifo_rd), 32'h0);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    $display("step reset: outputs idle");

    // Single 60-byte frame, payload 0x00..0x3B.
    for (int i = 0; i < 60; i++) pay[i] = 8'(i);
    p0 = ptr_pops; d0 = data_pops;
    send_frame(16'd60);
    wait_frames(1, 400);
    check("len60_ptr_pops", 32'(ptr_pops - p0), 32'd1);
    check("len60_data_pops", 32'(data_pops - d0), 32'd60);
    $display("step len60: frames=%0d", frames_seen);

    // Short frame, padded to 60.
    for (int i = 0; i < 14; i++) pay[i] = 8'($urandom_range(0, 255));
    p0 = ptr_pops; d0 = data_pops;
    send_frame(16'd14);
    wait_frames(2, 400);
    check("len14_data_pops", 32'(data_pops - d0), 32'd14);
    $display("step len14: frames=%0d", frames_seen);

    // Known-answer CRC on the unpadded instance.
    kat = "123456789";
    for (int i = 0; i < 9; i++) n_data_q.push_back(kat[i]);
    n_ptr_q.push_back(16'd9);
    n0 = 0; got = 1'b0;
    for (int c = 0; c < 300 && !got; c++) begin
      @(negedge clk);
      if (n_tx_en && n0 < 64) begin
        cap0[n0] = n_txd;
        n0++;
        if (n_done) got = 1'b1;
      end
    end
    check("kat_tx_en_cycles", 32'(n0), 32'd21);
    check("kat_first_data", 32'(cap0[8]), 32'h31);
    check("kat_fcs0", 32'(cap0[17]), 32'h26);
    check("kat_fcs1", 32'(cap0[18]), 32'h39);
    check("kat_fcs2", 32'(cap0[19]), 32'hF4);
    check("kat_fcs3", 32'(cap0[20]), 32'hCB);
    $display("step kat: captured %0d bytes", n0);

    // Three back-to-back 64-byte frames.
    gap_q.delete();
    d0 = data_pops;
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 64; i++) pay[i] = 8'((f << 6) + i);
      send_frame(16'd64);
    end
    wait_frames(5, 1000);
    check("b2b_data_pops", 32'(data_pops - d0), 32'd192);
    check("b2b_frames_seen", 32'(gap_q.size()), 32'd3);
    if (gap_q.size() == 3) begin
      check("b2b_gap_1_2", 32'(gap_q[1]), 32'd14);
      check("b2b_gap_2_3", 32'(gap_q[2]), 32'd14);
    end
    $display("step b2b: frames=%0d", frames_seen);

    // Zero-length pointer, then len=61 (upper pointer bits set, must be ignored).
    p0 = ptr_pops; d0 = data_pops;
    send_frame(16'hA000);
    for (int i = 0; i < 61; i++) pay[i] = 8'(8'hC0 ^ i);
    send_frame(16'h503D);
    wait_frames(6, 500);
    check("len0_ptr_pops", 32'(ptr_pops - p0), 32'd2);
    check("len0_data_pops", 32'(data_pops - d0), 32'd61);
    repeat (20) @(negedge clk);
    check("len0_frames_seen", 32'(frames_seen), 32'd6);
    $display("step len0+len61: frames=%0d", frames_seen);

    // Reset during data byte 20 of a 100-byte frame.
    for (int i = 0; i < 100; i++) pay[i] = 8'($urandom_range(0, 255));
    send_frame(16'd100);
    n = 0;
    while (cap_len != 28 && n < 400) begin
      @(posedge clk);
      n++;
    end
    check("rst_mid_point_reached", 32'(cap_len), 32'd28);
    #1;
    check("rst_mid_tx_en_before", 32'(gmii_tx_en), 32'd1);
    check("rst_mid_data_rd_before", 32'(data_fifo_rd), 32'd1);
    #1 rstn = 1'b0;
    #1;
    check("rst_mid_tx_en", 32'(gmii_tx_en), 32'd0);
    check("rst_mid_data_rd", 32'(data_fifo_rd), 32'd0);
    check("rst_mid_txd", 32'(gmii_txd), 32'd0);
    repeat (3) @(negedge clk);
    data_q.delete();
    void'(exp_lens.pop_front());
    exp_bytes.delete();
    rstn = 1'b1;
    p0 = ptr_pops; d0 = data_pops; en_cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (gmii_tx_en) en_cnt++;
    end
    check("post_rst_idle_tx_en", 32'(en_cnt), 32'd0);
    check("post_rst_ptr_pops", 32'(ptr_pops - p0), 32'd0);
    check("post_rst_data_pops", 32'(data_pops - d0), 32'd0);
    $display("step reset-mid-frame: idle after release");

    // Normal frame after reset recovery.
    for (int i = 0; i < 60; i++) pay[i] = 8'(i * 3);
    d0 = data_pops;
    send_frame(16'd60);
    wait_frames(7, 400);
    check("recover_data_pops", 32'(data_pops - d0), 32'd60);
    $display("step recover: frames=%0d", frames_seen);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
